// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, branch condition codes and sequencer FSM states.
package cpu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_XOR = 4'h3;
   localparam logic [3:0] OP_SLL = 4'h4;
   localparam logic [3:0] OP_SRA = 4'h5;
   localparam logic [3:0] OP_ROR = 4'h6;
   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] CC_NE = 3'b000;
   localparam logic [2:0] CC_EQ = 3'b001;
   localparam logic [2:0] CC_GT = 3'b010;
   localparam logic [2:0] CC_LT = 3'b011;
   localparam logic [2:0] CC_GE = 3'b100;
   localparam logic [2:0] CC_LE = 3'b101;
   localparam logic [2:0] CC_OV = 3'b110;
   localparam logic [2:0] CC_UN = 3'b111;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction/flag inputs and PC/status outputs of the PC sequencer.
interface pc_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic [15:0]       instruction;
   logic [ADDR_W-1:0] branch_reg_val;
   logic [2:0]        flags;
   logic              stall;
   logic              squash;
   logic              resume;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus_two;
   logic              do_if_flush;
   logic              halted;
   logic [2:0]        flags_q;

   modport master (
      output instruction, branch_reg_val, flags, stall, squash, resume,
      input  pc, pc_plus_two, do_if_flush, halted, flags_q
   );

   modport slave (
      input  instruction, branch_reg_val, flags, stall, squash, resume,
      output pc, pc_plus_two, do_if_flush, halted, flags_q
   );
endinterface

// File: rtl/branch_cond_unit.sv
// {N,Z,V} flag register and branch condition evaluation on the registered flags.
module branch_cond_unit
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic [2:0] condition,
   input  logic [2:0] flags,
   input  logic       update_en,
   output logic [2:0] flags_q,
   output logic       condition_met
);
   logic [2:0] r_flags;
   logic [2:0] w_flags_d;
   logic       w_n, w_z, w_v;

   // Logic/shift ops only define Z; N and V keep the last arithmetic result.
   always_comb begin
      w_flags_d = r_flags;
      if (update_en) begin
         case (opcode)
            OP_ADD, OP_SUB:                 w_flags_d = flags;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_flags_d[1] = flags[1];
            default:                        w_flags_d = r_flags;
         endcase
      end
   end

   dff #(.W(3), .RST_VAL(3'b000)) u_flags_ff (
      .clk(clk), .rst(~rst_n), .d(w_flags_d), .q(r_flags)
   );

   assign {w_n, w_z, w_v} = r_flags;

   always_comb begin
      condition_met = 1'b0;
      case (condition)
         CC_NE: condition_met = ~w_z;
         CC_EQ: condition_met = w_z;
         CC_GT: condition_met = ~w_z & ~w_n;
         CC_LT: condition_met = w_n;
         CC_GE: condition_met = w_z | ~w_n;
         CC_LE: condition_met = w_n | w_z;
         CC_OV: condition_met = w_v;
         CC_UN: condition_met = 1'b1;
         default: condition_met = 1'b0;
      endcase
   end

   assign flags_q = r_flags;
endmodule

// File: rtl/dff.sv
// Generic D flip-flop cell with asynchronous active-high reset to RST_VAL.
module dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: next-PC selection, branch resolution, flush and RUN/HALTED control.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                OFF_W    = 9,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);
   logic [ADDR_W-1:0] r_pc;
   logic [0:0]        r_state;
   state_e            w_state;
   state_e            w_next_state;
   logic [ADDR_W-1:0] w_next_pc;
   logic [ADDR_W-1:0] w_pc_plus_two;
   logic [ADDR_W-1:0] w_off_sext;
   logic [ADDR_W-1:0] w_target;
   logic [3:0]        w_opcode;
   logic [2:0]        w_cond;
   logic              w_run;
   logic              w_update_en;
   logic              w_cond_met;
   logic              w_taken;
   logic [2:0]        w_flags_q;

   assign w_state  = state_e'(r_state);
   assign w_run    = (w_state == ST_RUN);
   assign w_opcode = bus.instruction[15:12];
   assign w_cond   = bus.instruction[11:9];

   assign w_update_en = w_run & ~bus.squash & ~bus.stall & (bus.instruction != 16'h0000);

   branch_cond_unit u_bcu (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (w_opcode),
      .condition    (w_cond),
      .flags        (bus.flags),
      .update_en    (w_update_en),
      .flags_q      (w_flags_q),
      .condition_met(w_cond_met)
   );

   assign w_pc_plus_two = r_pc + ADDR_W'(2);
   assign w_off_sext    = {{(ADDR_W-OFF_W){bus.instruction[OFF_W-1]}}, bus.instruction[OFF_W-1:0]};
   assign w_target      = (w_opcode == OP_BR) ? bus.branch_reg_val
                                              : w_pc_plus_two + (w_off_sext << 1);

   // Stall does not gate the branch: a resolved branch must redirect fetch anyway.
   assign w_taken = w_run & ~bus.squash & ((w_opcode == OP_B) | (w_opcode == OP_BR)) & w_cond_met;

   always_comb begin
      w_next_pc    = r_pc;
      w_next_state = w_state;
      if (w_state == ST_HALTED) begin
         if (bus.resume) begin
            w_next_pc    = w_pc_plus_two;
            w_next_state = ST_RUN;
         end
      end else if (w_taken) begin
         w_next_pc = w_target;
      end else if (bus.stall) begin
         w_next_pc = r_pc;
      end else if ((w_opcode == OP_HLT) && !bus.squash) begin
         w_next_state = ST_HALTED;
      end else begin
         w_next_pc = w_pc_plus_two;
      end
   end

   dff #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc_ff (
      .clk(clk), .rst(~rst_n), .d(w_next_pc), .q(r_pc)
   );

   dff #(.W(1), .RST_VAL(1'b0)) u_state_ff (
      .clk(clk), .rst(~rst_n), .d(w_next_state), .q(r_state)
   );

   assign bus.pc          = r_pc;
   assign bus.pc_plus_two = w_pc_plus_two;
   assign bus.do_if_flush = w_taken;
   assign bus.halted      = (w_state == ST_HALTED);
   assign bus.flags_q     = w_flags_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 16-bit instance for function, 10-bit instance for wrap.
module tb_pc_sequencer;
   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rst_n2 = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(16)) bus  ();
   pc_sequencer_if #(.ADDR_W(10)) bus2 ();

   pc_sequencer #(.ADDR_W(16), .OFF_W(9), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   pc_sequencer #(.ADDR_W(10), .OFF_W(9), .RESET_PC(10'h3FC)) dut2 (
      .clk(clk), .rst_n(rst_n2), .bus(bus2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instruction  = 16'h0000; bus.branch_reg_val  = 16'h0000; bus.flags  = 3'b000;
      bus.stall  = 1'b0; bus.squash  = 1'b0; bus.resume  = 1'b0;
      bus2.instruction = 16'h0000; bus2.branch_reg_val = 10'h000;  bus2.flags = 3'b000;
      bus2.stall = 1'b0; bus2.squash = 1'b0; bus2.resume = 1'b0;

      // Reset state
      #3;
      chk("rst_pc",     bus.pc,          32'h0);
      chk("rst_flags",  bus.flags_q,     32'h0);
      chk("rst_halted", bus.halted,      32'h0);
      chk("rst_flush",  bus.do_if_flush, 32'h0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("nop_pc0", bus.pc, 32'h0);
      tick; chk("nop_pc2", bus.pc, 32'h2);
      tick; chk("nop_pc4", bus.pc, 32'h4);
      tick; chk("nop_pc6", bus.pc, 32'h6);
      chk("nop_pc_plus_two", bus.pc_plus_two, 32'h8);
      chk("nop_flags", bus.flags_q, 32'h0);
      tick; tick; tick; tick;
      chk("nop_pcE", bus.pc, 32'hE);

      // ADD sets Z, then B EQ -2 words at 0x10
      bus.instruction = 16'h0123; bus.flags = 3'b010;
      tick;
      chk("add_pc", bus.pc, 32'h10);
      chk("add_flags", bus.flags_q, 32'h2);
      bus.instruction = 16'hC3FE; bus.flags = 3'b000; #1;
      chk("beq_flush", bus.do_if_flush, 32'h1);
      tick;
      chk("beq_pc", bus.pc, 32'hE);
      chk("beq_flags_hold", bus.flags_q, 32'h2);
      bus.instruction = 16'h0000; #1;
      chk("beq_flush_drop", bus.do_if_flush, 32'h0);
      tick;
      chk("pc10_again", bus.pc, 32'h10);

      // Taken branch beats stall
      bus.instruction = 16'hC3FE; bus.stall = 1'b1; #1;
      chk("beq_stall_flush", bus.do_if_flush, 32'h1);
      tick;
      chk("beq_stall_pc", bus.pc, 32'hE);
      bus.instruction = 16'h0000; bus.stall = 1'b0;
      tick;
      chk("pc10_third", bus.pc, 32'h10);

      // Squashed branch falls through
      bus.instruction = 16'hC3FE; bus.squash = 1'b1; #1;
      chk("beq_squash_flush", bus.do_if_flush, 32'h0);
      tick;
      chk("beq_squash_pc", bus.pc, 32'h12);
      bus.squash = 1'b0;

      // Stall holds PC and blocks flag update
      bus.instruction = 16'h0123; bus.flags = 3'b101; bus.stall = 1'b1;
      tick;
      chk("stall_pc", bus.pc, 32'h12);
      chk("stall_flags", bus.flags_q, 32'h2);
      bus.stall = 1'b0;

      // Z-only update (opcode 3): N,V hold at 0, Z cleared
      bus.instruction = 16'h3456; bus.flags = 3'b101;
      tick;
      chk("zonly_flags", bus.flags_q, 32'h0);
      chk("zonly_pc", bus.pc, 32'h14);

      // SUB sets N
      bus.instruction = 16'h1111; bus.flags = 3'b100;
      tick;
      chk("sub_flags", bus.flags_q, 32'h4);
      chk("sub_pc", bus.pc, 32'h16);

      // B GT not taken with N=1; B LT +4 words taken to 0x20
      bus.instruction = 16'hC404; bus.flags = 3'b000; #1;
      chk("bgt_flush", bus.do_if_flush, 32'h0);
      bus.instruction = 16'hC604; #1;
      chk("blt_flush", bus.do_if_flush, 32'h1);
      tick;
      chk("blt_pc", bus.pc, 32'h20);

      // HLT at 0x20, then ignore BR UN / flags for 5 cycles
      bus.instruction = 16'hF000;
      tick;
      chk("hlt_halted", bus.halted, 32'h1);
      chk("hlt_pc", bus.pc, 32'h20);
      for (int i = 0; i < 5; i++) begin
         bus.instruction = 16'hDE00; bus.branch_reg_val = 16'h1234;
         bus.flags = (i % 2 == 0) ? 3'b011 : 3'b110; #1;
         chk("halt_flush", bus.do_if_flush, 32'h0);
         tick;
         chk("halt_pc", bus.pc, 32'h20);
         chk("halt_state", bus.halted, 32'h1);
      end
      chk("halt_flags_hold", bus.flags_q, 32'h4);
      bus.instruction = 16'h0000; bus.resume = 1'b1;
      tick;
      bus.resume = 1'b0;
      chk("resume_pc", bus.pc, 32'h22);
      chk("resume_halted", bus.halted, 32'h0);
      tick;
      chk("run_after_resume", bus.pc, 32'h24);

      // BR UN in RUN jumps to register value
      bus.instruction = 16'hDE00; bus.branch_reg_val = 16'h1234; #1;
      chk("br_flush", bus.do_if_flush, 32'h1);
      tick;
      chk("br_pc", bus.pc, 32'h1234);

      // Resume in RUN is ignored
      bus.instruction = 16'h0000; bus.resume = 1'b1;
      tick;
      bus.resume = 1'b0;
      chk("resume_run_pc", bus.pc, 32'h1236);
      chk("resume_run_halted", bus.halted, 32'h0);

      // Async reset during HALTED
      bus.instruction = 16'hF000;
      tick;
      chk("hlt2_halted", bus.halted, 32'h1);
      bus.instruction = 16'h0000;
      @(negedge clk); #2; rst_n = 1'b0; #1;
      chk("async_rst_pc", bus.pc, 32'h0);
      chk("async_rst_halted", bus.halted, 32'h0);
      chk("async_rst_flags", bus.flags_q, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      tick;
      chk("post_rst_pc", bus.pc, 32'h2);

      // 10-bit instance: wrap on increment and on B target
      chk("w10_rst_pc", bus2.pc, 32'h3FC);
      @(negedge clk); rst_n2 = 1'b1;
      tick;
      chk("w10_pc3FE", bus2.pc, 32'h3FE);
      chk("w10_pp2_wrap", bus2.pc_plus_two, 32'h000);
      tick;
      chk("w10_inc_wrap", bus2.pc, 32'h000);
      rst_n2 = 1'b0; #1;
      chk("w10_rst2_pc", bus2.pc, 32'h3FC);
      @(negedge clk); rst_n2 = 1'b1;
      bus2.instruction = 16'hCE01; #1;
      chk("w10_bun_flush", bus2.do_if_flush, 32'h1);
      tick;
      chk("w10_b_wrap", bus2.pc, 32'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
